// File: rtl/multisim_client_pull_arbiter.sv
// Round-robin arbiter sharing one multisim_client_pull channel between N_REQ consumers.
// Each pulled item sits in a one-entry holding register until the granted consumer takes it.
module multisim_client_pull_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int N_REQ      = 4,
  parameter int MAX_BURST  = 4,
  localparam int IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  output logic [N_REQ-1:0]      dn_vld,
  input  logic [N_REQ-1:0]      dn_rdy,
  output logic [DATA_WIDTH-1:0] dn_data,
  input  logic                  up_vld,
  output logic                  up_rdy,
  input  logic [DATA_WIDTH-1:0] up_data,
  output logic                  grant_vld,
  output logic [IDX_W-1:0]      grant_id
);

  localparam int               BURST_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    PULL,
    DELIVER
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      pick_id;
  logic [IDX_W-1:0]      next_ptr;
  logic [BURST_W-1:0]    burst_cnt;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  any_req;
  logic                  req_granted;
  logic                  up_hs;
  logic                  dn_hs;
  logic                  burst_more;

  assign any_req     = |req;
  assign req_granted = req[grant_id];
  assign up_hs       = (state == PULL) && up_vld && req_granted;
  assign dn_hs       = (state == DELIVER) && dn_rdy[grant_id];
  assign burst_more  = req_granted && (burst_cnt < BURST_LAST);
  assign next_ptr    = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;

  // Scanning downward lets the lowest rotated offset win without a found flag.
  always_comb begin
    int idx;
    idx     = 0;
    pick_id = rr_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (req[IDX_W'(idx)]) begin
        pick_id = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = PULL;
        end
      end
      PULL: begin
        if (up_hs) begin
          state_nxt = DELIVER;
        end else if (!req_granted) begin
          state_nxt = IDLE;
        end
      end
      DELIVER: begin
        if (dn_hs) begin
          state_nxt = burst_more ? PULL : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    up_rdy    = 1'b0;
    dn_vld    = '0;
    grant_vld = 1'b0;
    dn_data   = hold_data;
    case (state)
      PULL: begin
        up_rdy    = req_granted;
        grant_vld = 1'b1;
      end
      DELIVER: begin
        dn_vld[grant_id] = 1'b1;
        grant_vld        = 1'b1;
      end
      default: ;
    endcase
  end

  // Priority only rotates when a grant ends, so a burst keeps its consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_id  <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      hold_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id  <= pick_id;
            burst_cnt <= '0;
          end
        end
        PULL: begin
          if (up_hs) begin
            hold_data <= up_data;
          end else if (!req_granted) begin
            rr_ptr <= next_ptr;
          end
        end
        DELIVER: begin
          if (dn_hs) begin
            if (burst_more) begin
              burst_cnt <= burst_cnt + 1'b1;
            end else begin
              rr_ptr <= next_ptr;
            end
          end
        end
        default: ;
      endcase
    end
  end

  a_dn_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(dn_vld));
  a_no_overlap : assert property (@(posedge clk) disable iff (rst) !(up_rdy && (|dn_vld)));

endmodule

// File: tb/tb_multisim_client_pull_arbiter.sv
// Scoreboard bench: expected deliveries are queued as stimulus is driven and matched on dn handshakes.
// Instance a uses MAX_BURST=4, instance b MAX_BURST=1; use_b selects which one is observed.
module tb_multisim_client_pull_arbiter;

  typedef struct packed {
    logic [1:0]  id;
    logic [63:0] data;
  } item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'hF;
  logic [3:0]  dn_rdy = 4'hF;
  logic        up_vld = 1'b1;
  logic [63:0] up_data = 64'd0;
  logic        use_b = 1'b0;

  logic [3:0]  dn_vld_a, dn_vld_b, dn_vld_sel;
  logic [63:0] dn_data_a, dn_data_b, dn_data_sel;
  logic        up_rdy_a, up_rdy_b, up_rdy_sel;
  logic        grant_vld_a, grant_vld_b, grant_vld_sel;
  logic [1:0]  grant_id_a, grant_id_b, grant_id_sel;

  item_t       sb_q[$];
  int          checks_total = 0;
  int          checks_passed = 0;
  int          fire_cnt = 0;
  int          fire_before;
  logic        inc_pending = 1'b0;
  logic [63:0] exp_data;

  always #5 clk = ~clk;

  multisim_client_pull_arbiter #(.DATA_WIDTH(64), .N_REQ(4), .MAX_BURST(4)) u_dut_a (
    .clk(clk), .rst(rst), .req(req), .dn_vld(dn_vld_a), .dn_rdy(dn_rdy), .dn_data(dn_data_a),
    .up_vld(up_vld), .up_rdy(up_rdy_a), .up_data(up_data),
    .grant_vld(grant_vld_a), .grant_id(grant_id_a)
  );

  multisim_client_pull_arbiter #(.DATA_WIDTH(64), .N_REQ(4), .MAX_BURST(1)) u_dut_b (
    .clk(clk), .rst(rst), .req(req), .dn_vld(dn_vld_b), .dn_rdy(dn_rdy), .dn_data(dn_data_b),
    .up_vld(up_vld), .up_rdy(up_rdy_b), .up_data(up_data),
    .grant_vld(grant_vld_b), .grant_id(grant_id_b)
  );

  assign dn_vld_sel    = use_b ? dn_vld_b : dn_vld_a;
  assign dn_data_sel   = use_b ? dn_data_b : dn_data_a;
  assign up_rdy_sel    = use_b ? up_rdy_b : up_rdy_a;
  assign grant_vld_sel = use_b ? grant_vld_b : grant_vld_a;
  assign grant_id_sel  = use_b ? grant_id_b : grant_id_a;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks_total++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end else begin
      checks_passed++;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic uv, input logic [3:0] dr);
    req    = r;
    up_vld = uv;
    dn_rdy = dr;
  endtask

  task automatic pushExpected(input logic [1:0] id, input logic [63:0] data);
    item_t it;
    it.id   = id;
    it.data = data;
    sb_q.push_back(it);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Upstream source: a new word appears after each accepted one.
  always @(posedge clk) begin
    if (inc_pending) begin
      inc_pending = 1'b0;
      #1 up_data = up_data + 64'd1;
    end
  end

  // Handshakes are judged mid-cycle, ahead of the edge that completes them.
  always @(negedge clk) begin
    item_t      exp_it;
    logic [1:0] got_id;
    if (!rst) begin
      if (up_vld && up_rdy_sel) begin
        fire_cnt++;
        inc_pending = 1'b1;
      end
      if (|(dn_vld_sel & dn_rdy)) begin
        if (sb_q.size() == 0) begin
          checkOutput("sb_unexpected", 64'(dn_vld_sel), 64'd0);
        end else begin
          exp_it = sb_q.pop_front();
          got_id = 2'd0;
          for (int i = 0; i < 4; i++) begin
            if (dn_vld_sel[i]) got_id = 2'(i);
          end
          checkOutput("sb_id", 64'(got_id), 64'(exp_it.id));
          checkOutput("sb_data", dn_data_sel, exp_it.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with everything requesting and upstream offering data
    tick();
    checkOutput("rst_dn_vld", 64'(dn_vld_a), 64'd0);
    checkOutput("rst_up_rdy", 64'(up_rdy_a), 64'd0);
    checkOutput("rst_grant_vld", 64'(grant_vld_a), 64'd0);
    tick();
    checkOutput("rst_dn_vld2", 64'(dn_vld_a), 64'd0);
    checkOutput("rst_up_rdy2", 64'(up_rdy_a), 64'd0);
    checkOutput("rst_grant_vld2", 64'(grant_vld_a), 64'd0);
    checkOutput("rst_dn_data", dn_data_a, 64'd0);
    rst = 1'b0;
    tick();
    checkOutput("first_grant_vld", 64'(grant_vld_a), 64'd1);
    checkOutput("first_grant_id", 64'(grant_id_a), 64'd0);
    checkOutput("first_up_rdy", 64'(up_rdy_a), 64'd1);
    applyStimulus(4'b0000, 1'b0, 4'hF);
    tick();
    checkOutput("first_abandon", 64'(grant_vld_a), 64'd0);

    // Single item to consumer 2
    up_data = 64'hCAFE;
    applyStimulus(4'b0100, 1'b1, 4'hF);
    tick();
    checkOutput("single_up_rdy", 64'(up_rdy_a), 64'd1);
    checkOutput("single_grant_id", 64'(grant_id_a), 64'd2);
    pushExpected(2'd2, 64'hCAFE);
    tick();
    checkOutput("single_dn_vld", 64'(dn_vld_a), 64'h4);
    checkOutput("single_dn_data", dn_data_a, 64'hCAFE);
    checkOutput("single_up_rdy_off", 64'(up_rdy_a), 64'd0);
    applyStimulus(4'b0000, 1'b0, 4'hF);
    tick();
    checkOutput("single_idle", 64'(grant_vld_a), 64'd0);
    checkOutput("single_dn_off", 64'(dn_vld_a), 64'd0);

    // Round robin with MAX_BURST=1
    rst = 1'b1;
    use_b = 1'b1;
    applyStimulus(4'b0000, 1'b0, 4'h0);
    tick();
    rst = 1'b0;
    up_data = 64'h3000;
    for (int k = 0; k < 5; k++) pushExpected(2'(k % 4), 64'h3000 + 64'(k));
    applyStimulus(4'hF, 1'b1, 4'hF);
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) tick();
    applyStimulus(4'b0000, 1'b0, 4'hF);
    checkOutput("rr_drain", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    tick();
    checkOutput("rr_idle", 64'(grant_vld_b), 64'd0);

    // Burst limit with MAX_BURST=4
    rst = 1'b1;
    use_b = 1'b0;
    applyStimulus(4'b0000, 1'b0, 4'h0);
    tick();
    rst = 1'b0;
    up_data = 64'h4000;
    for (int k = 0; k < 12; k++) pushExpected((k >= 4 && k < 8) ? 2'd1 : 2'd0, 64'h4000 + 64'(k));
    applyStimulus(4'b0011, 1'b1, 4'hF);
    for (int i = 0; i < 80 && sb_q.size() != 0; i++) tick();
    applyStimulus(4'b0000, 1'b0, 4'hF);
    checkOutput("burst_drain", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    tick();
    checkOutput("burst_idle", 64'(grant_vld_a), 64'd0);

    // Backpressure in DELIVER while the request is withdrawn
    applyStimulus(4'b0010, 1'b1, 4'h0);
    tick();
    checkOutput("bp_up_rdy", 64'(up_rdy_a), 64'd1);
    checkOutput("bp_grant_id", 64'(grant_id_a), 64'd1);
    exp_data = up_data;
    pushExpected(2'd1, exp_data);
    tick();
    applyStimulus(4'b0000, 1'b1, 4'h0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_dn_vld", 64'(dn_vld_a), 64'h2);
      checkOutput("bp_dn_data", dn_data_a, exp_data);
      checkOutput("bp_up_rdy_off", 64'(up_rdy_a), 64'd0);
      tick();
    end
    applyStimulus(4'b0000, 1'b1, 4'hF);
    tick();
    checkOutput("bp_idle", 64'(grant_vld_a), 64'd0);
    checkOutput("bp_dn_off", 64'(dn_vld_a), 64'd0);

    // Abandon during PULL with no upstream data
    applyStimulus(4'b0001, 1'b0, 4'h0);
    fire_before = fire_cnt;
    tick();
    checkOutput("ab_up_rdy", 64'(up_rdy_a), 64'd1);
    checkOutput("ab_grant_id", 64'(grant_id_a), 64'd0);
    applyStimulus(4'b0000, 1'b0, 4'h0);
    tick();
    checkOutput("ab_idle", 64'(grant_vld_a), 64'd0);
    checkOutput("ab_up_rdy_off", 64'(up_rdy_a), 64'd0);
    checkOutput("ab_no_fire", 64'(fire_cnt), 64'(fire_before));

    // Reset in DELIVER loses the held item
    applyStimulus(4'b0001, 1'b1, 4'h0);
    tick();
    tick();
    checkOutput("rd_dn_vld", 64'(dn_vld_a), 64'h1);
    rst = 1'b1;
    applyStimulus(4'b0000, 1'b0, 4'h0);
    tick();
    checkOutput("rd_dn_off", 64'(dn_vld_a), 64'd0);
    checkOutput("rd_grant_off", 64'(grant_vld_a), 64'd0);
    checkOutput("rd_dn_data", dn_data_a, 64'd0);
    rst = 1'b0;
    applyStimulus(4'b0000, 1'b0, 4'hF);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("rd_still_idle", 64'(dn_vld_a), 64'd0);

    checkOutput("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
